// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// After each grant it waits a fixed frame time, since uart_tx reports no completion.
module uart_tx_sched #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP        = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_trig,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam logic [31:0] FRAME_CYCLES = 32'(BAUD_DIV * FRAME_BITS + GAP);
    localparam logic [31:0] FRAME_LAST   = FRAME_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [3:0]  r_ack;
    logic        r_tx_trig;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic [1:0]  r_grant_id;

    logic [1:0]  w_cand [4];
    logic [1:0]  w_sel;
    logic [7:0]  w_sel_data;

    // Candidate k is the k-th requester after the last grant, so the one
    // granted last is always considered last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand[gi] = r_grant_id + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        w_sel = w_cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_sel = w_cand[k];
            end
        end
    end

    assign w_sel_data = req_data[{w_sel, 3'b000} +: 8];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_tx_trig  <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant_id <= w_sel;
                        r_tx_data  <= w_sel_data;
                        r_ack      <= 4'b0001 << w_sel;
                        r_tx_trig  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    r_tx_trig <= 1'b0;
                    r_ack     <= '0;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == FRAME_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_trig  = r_tx_trig;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a short frame (FRAME_CYCLES = 42).
// Outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_sched;

    localparam int BUSY_CYCLES = 43;  // TRIG + 42 WAIT cycles
    localparam int SPACING     = 44;  // TRIG + WAIT + one IDLE cycle

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        tx_trig;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    uart_tx_sched #(
        .BAUD_DIV   (4),
        .FRAME_BITS (10),
        .GAP        (2)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_trig  (tx_trig),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_data;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_grant(input int idx, input vec_t v);
        int n;
        wait_idle();
        req      = v.req;
        req_data = v.data;
        @(negedge CLK);
        chk($sformatf("v%0d_trig", idx), 32'(tx_trig), 32'd1);
        chk($sformatf("v%0d_ack", idx), 32'(ack), 32'(v.exp_ack));
        chk($sformatf("v%0d_data", idx), 32'(tx_data), 32'(v.exp_data));
        chk($sformatf("v%0d_gid", idx), 32'(grant_id), 32'(v.exp_gid));
        req = '0;
        n = 1;
        forever begin
            @(negedge CLK);
            if (busy !== 1'b1 || n >= 200) break;
            n++;
        end
        chk($sformatf("v%0d_busy_len", idx), 32'(n), 32'(BUSY_CYCLES));
        chk($sformatf("v%0d_data_hold", idx), 32'(tx_data), 32'(v.exp_data));
        $display("vec %0d: req=%b ack=%b data=%02h gid=%0d busy=%0d", idx, v.req, v.exp_ack,
                 v.exp_data, v.exp_gid, n);
    endtask

    initial begin
        int np, last_t, n, extra;

        // Grant order hand-traced from grant_id=3 after reset.
        vecs[0] = '{4'b0001, 32'hDDCCBB55, 4'b0001, 8'h55, 2'd0};
        vecs[1] = '{4'b0101, 32'h44332211, 4'b0100, 8'h33, 2'd2};
        vecs[2] = '{4'b0101, 32'h88776644, 4'b0001, 8'h44, 2'd0};
        vecs[3] = '{4'b0101, 32'h0C0B0A09, 4'b0100, 8'h0B, 2'd2};
        vecs[4] = '{4'b1001, 32'hF0E0D0C0, 4'b1000, 8'hF0, 2'd3};
        vecs[5] = '{4'b1111, 32'h13121110, 4'b0001, 8'h10, 2'd0};
        vecs[6] = '{4'b0110, 32'h27262524, 4'b0010, 8'h25, 2'd1};
        vecs[7] = '{4'b1000, 32'h3B3A3938, 4'b1000, 8'h3B, 2'd3};
        vecs[8] = '{4'b0010, 32'h4F4E4D4C, 4'b0010, 8'h4D, 2'd1};
        vecs[9] = '{4'b1000, 32'h5A5B5C5D, 4'b1000, 8'h5A, 2'd3};

        #50;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig", 32'(tx_trig), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd3);
        $display("reset: busy=%0d trig=%0d ack=%b data=%02h gid=%0d", busy, tx_trig, ack, tx_data, grant_id);
        #50 RSTn = 1'b1;
        repeat (10) @(negedge CLK);

        for (int i = 0; i < 10; i++) do_grant(i, vecs[i]);

        // All four requesting: strict rotation 0..3, then nothing more.
        wait_idle();
        req = 4'b1111;
        req_data = 32'hA3A2A1A0;
        np = 0;
        last_t = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge CLK);
            if (tx_trig === 1'b1) begin
                if (np < 4) begin
                    chk($sformatf("all_ack%0d", np), 32'(ack), 32'(4'b0001 << np));
                    chk($sformatf("all_data%0d", np), 32'(tx_data), 32'h0A0 + 32'(np));
                    if (np > 0) chk($sformatf("all_gap%0d", np), 32'(cyc - last_t), 32'(SPACING));
                end
                $display("all: pulse %0d cyc=%0d ack=%b data=%02h", np, cyc, ack, tx_data);
                last_t = cyc;
                np++;
                req = req & ~ack;
            end
        end
        chk("all_pulses", 32'(np), 32'd4);

        // Lone requester held high, next byte presented after each ack.
        wait_idle();
        req = 4'b1000;
        req_data = 32'h01000000;
        np = 0;
        last_t = 0;
        for (int cyc = 0; cyc < 200 && np < 3; cyc++) begin
            @(negedge CLK);
            if (tx_trig === 1'b1) begin
                chk($sformatf("cont_ack%0d", np), 32'(ack), 32'(4'b1000));
                chk($sformatf("cont_data%0d", np), 32'(tx_data), 32'(np + 1));
                if (np > 0) chk($sformatf("cont_gap%0d", np), 32'(cyc - last_t), 32'(SPACING));
                $display("cont: pulse %0d cyc=%0d data=%02h", np, cyc, tx_data);
                last_t = cyc;
                np++;
                if (np < 3) req_data = 32'(np + 1) << 24;
                else req = '0;
            end
        end
        chk("cont_pulses", 32'(np), 32'd3);

        // Short req[1] pulse inside WAIT must be lost.
        wait_idle();
        req = 4'b0001;
        req_data = 32'h00000066;
        @(negedge CLK);
        chk("lost_first_trig", 32'(tx_trig), 32'd1);
        req = '0;
        repeat (10) @(negedge CLK);
        req = 4'b0010;
        repeat (3) @(negedge CLK);
        req = '0;
        extra = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge CLK);
            if (tx_trig === 1'b1 || ack[1] === 1'b1) extra++;
        end
        chk("lost_extra", 32'(extra), 32'd0);
        chk("lost_idle", 32'(busy), 32'd0);
        $display("lost: extra=%0d busy=%0d", extra, busy);

        // Asynchronous reset in the middle of WAIT.
        req = 4'b0100;
        req_data = 32'h00770000;
        @(negedge CLK);
        chk("rw_ack", 32'(ack), 32'(4'b0100));
        req = '0;
        repeat (21) @(negedge CLK);
        chk("rw_busy_before", 32'(busy), 32'd1);
        #2 RSTn = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_trig", 32'(tx_trig), 32'd0);
        chk("rw_data", 32'(tx_data), 32'd0);
        chk("rw_gid", 32'(grant_id), 32'd3);
        $display("rst mid-wait: busy=%0d trig=%0d data=%02h gid=%0d", busy, tx_trig, tx_data, grant_id);
        @(negedge CLK);
        req = 4'b0010;
        req_data = 32'h00009900;
        @(negedge CLK);
        RSTn = 1'b1;
        n = 0;
        while (tx_trig !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("rw_latency_ok", 32'(n <= 2), 32'd1);
        chk("rw_new_ack", 32'(ack), 32'(4'b0010));
        chk("rw_new_gid", 32'(grant_id), 32'd1);
        chk("rw_new_data", 32'(tx_data), 32'h99);
        $display("after reset: cycles=%0d ack=%b gid=%0d data=%02h", n, ack, grant_id, tx_data);
        req = '0;
        repeat (50) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
